// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad debounce/decoder slice.
// Contents:
//   key_state_e   - debounce FSM states
//   KeyMap        - 4x4 key code table, indexed by {row_idx, col_idx}
//   onehot_valid  - true when a 4-bit vector has exactly one bit set
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle            = 2'd0,
    StDebouncePress   = 2'd1,
    StHeld            = 2'd2,
    StDebounceRelease = 2'd3
  } key_state_e;

  // Element r*4+c holds the code for row r, column c (element 0 is rightmost).
  localparam logic [15:0][3:0] KeyMap = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  function automatic logic onehot_valid(input logic [3:0] v);
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_decoder.sv
// Combinational row/column to hex key code mapping.
// Ports:
//   row_i   - one-hot row
//   col_i   - one-hot column
//   code_o  - hex key code from KeyMap
//   valid_o - both inputs are exactly one-hot
module key_decoder
  import keypad_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [3:0] code_o,
  output logic       valid_o
);

  logic [1:0] row_idx;
  logic [1:0] col_idx;

  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_i[i]) row_idx = 2'(i);
      if (col_i[i]) col_idx = 2'(i);
    end
  end

  assign code_o  = KeyMap[{row_idx, col_idx}];
  assign valid_o = onehot_valid(row_i) && onehot_valid(col_i);

endmodule

// File: rtl/keypad_debounce_decoder.sv
// Debounces a single key press from the keypad scanner, emits its hex code with a
// one-cycle valid pulse and keeps a two-digit history.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   row, col    - one-hot scanner row drive and synchronized column sense
//   hold        - freezes the scanner while any key activity is in progress
//   key_valid   - one-cycle pulse on a confirmed press
//   key_code    - code of the last confirmed key
//   digit_new   - most recent confirmed key
//   digit_old   - key confirmed before digit_new
module keypad_debounce_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       hold,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       row_cap_q, row_cap_d;
  logic [3:0]       col_cap_q, col_cap_d;
  logic             hold_q, hold_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [3:0]       digit_new_q, digit_new_d;
  logic [3:0]       digit_old_q, digit_old_d;
  logic [3:0]       dec_code;
  logic             dec_valid;
  logic             press_qual;
  logic             cap_bit_high;

  // Decodes the captured key, so the code is stable for the whole debounce.
  key_decoder u_key_decoder (
    .row_i   (row_cap_q),
    .col_i   (col_cap_q),
    .code_o  (dec_code),
    .valid_o (dec_valid)
  );

  assign press_qual   = onehot_valid(row) && onehot_valid(col);
  assign cap_bit_high = (col & col_cap_q) != 4'b0000;
  assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_cap_d   = row_cap_q;
    col_cap_d   = col_cap_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    unique case (state_q)
      StIdle: begin
        if (press_qual) begin
          row_cap_d = row;
          col_cap_d = col;
          cnt_d     = '0;
          state_d   = StDebouncePress;
        end
      end
      StDebouncePress: begin
        // Exact match required: bounce, release or an extra key all abort.
        if (col != col_cap_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax && dec_valid) begin
          state_d     = StHeld;
          key_valid_d = 1'b1;
          key_code_d  = dec_code;
          digit_old_d = digit_new_q;
          digit_new_d = dec_code;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeld: begin
        // Only the captured column matters; other keys are ignored.
        if (!cap_bit_high) begin
          cnt_d   = '0;
          state_d = StDebounceRelease;
        end
      end
      StDebounceRelease: begin
        if (cap_bit_high) begin
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    hold_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      row_cap_q   <= 4'b0000;
      col_cap_q   <= 4'b0000;
      hold_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_cap_q   <= row_cap_d;
      col_cap_q   <= col_cap_d;
      hold_q      <= hold_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

  assign hold      = hold_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;

endmodule
